spart_bus_if: RTL and testbench
===============================

# spart_bus_if

Bus-side responder of the SPART: decodes the processor-side I/O bus (iocs/iorw/ioaddr/databus), holds the baud divisor, generates the 16x baud enable, and buffers bytes between the bus and the SPART transmit/receive cores. It answers the driver state machine's divisor loads, receive reads and transmit writes, and reports rda/tbr back to it. It sits between the driver and the tx/rx shift cores inside the SPART top level.

## Interface
- No parameters.
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- iocs  in  1  chip select; one bus transaction per cycle it is high.
- iorw  in  1  1 = read (responder drives databus), 0 = write.
- ioaddr  in  2  00 rx/tx data, 01 status, 10 DBL, 11 DBH.
- databus  inout  8  driven only when iocs=1 and iorw=1, else 8'hzz.
- rda  out  1  receive data available (rx buffer non-empty).
- tbr  out  1  transmit buffer ready (tx holding register empty).
- baud_en  out  1  one-cycle enable pulse at 16x baud rate.
- tx_data  out  8  byte handed to transmit core.
- tx_start  out  1  one-cycle pulse: transmit core loads tx_data.
- tx_busy  in  1  transmit core is shifting a frame.
- rx_data  in  8  byte from receive core.
- rx_valid  in  1  one-cycle pulse: rx_data holds a complete byte.

## Operation
- Divisor: 16-bit {DBH,DBL}; reset 16'h028B. Write addr 11 loads DBH, addr 10 loads DBL. Writes to addr 01 ignored.
- Baud generator: down counter; when 0, baud_en=1 that cycle and counter reloads divisor; else decrement. Period = divisor+1 cycles; divisor 0 -> baud_en every cycle.
- Divisor write reloads the counter at the same edge with the new 16-bit value (written byte + other retained byte).
- Tx path: write addr 00 with tbr=1 latches databus into holding register, tbr=0 next cycle. Write with tbr=0 is dropped (no effect). When holding full and tx_busy=0: tx_start pulses one cycle with tx_data = holding byte, holding empties, tbr=1 the following cycle.
- Rx path: rx_valid pushes rx_data into rx buffer. Read addr 00 drives head byte onto databus and pops at the edge; read when empty drives 8'h00, no pop.
- Status read (addr 01): databus = {5'b0, overrun, tbr, rda}; clears overrun at the edge.
- Overrun: rx_valid while buffer full and no pop that cycle -> byte dropped, overrun set (sticky). Push and pop in same cycle when full -> both succeed, no overrun.
- Read of addr 10/11 returns current DBL/DBH.

## Timing
- Reset values: rda=0, tbr=1, baud_en=0, tx_start=0, tx_data=8'h00, overrun=0, counter=16'h028B, databus hi-Z unless read in progress.
- Read data combinational: valid on databus the same cycle iocs&iorw are high.
- rda, tbr registered: reflect buffer state one cycle after the causing edge.
- Write-to-tx_start latency: 1 cycle minimum (holding loads at edge N, tx_start high cycle N+1 if tx_busy=0).
- Held iocs: each cycle is a separate transaction (a read held 3 cycles pops up to 3 bytes).
- Reset mid-operation: all buffers flushed, in-flight tx_start suppressed, divisor returns to 16'h028B.

## Configuration
- SPART_RX_FIFO_EN defined: rx buffer is a 4-entry FIFO with 2-bit wrapping pointers and 3-bit count; rda = count != 0; full at count 4.
- Undefined: rx buffer is a single holding register; full = rda; second rx_valid before read sets overrun.

## Test plan
- Reset, write DBH=8'h00, DBL=8'h03 -> baud_en pulses every 4 cycles, first pulse 4 cycles after DBL write edge.
- tx_busy=0, write 8'h41 to addr 00 -> tbr falls, tx_start pulses 1 cycle later with tx_data=8'h41, tbr=1 again; second write while tbr=0 leaves tx_data unchanged.
- rx_valid with 8'h5A, then read addr 00 -> databus=8'h5A same cycle, rda drops next cycle; read again -> 8'h00.
- FIFO build: push 8'h01..8'h05 without reads -> first four read back in order 01..04, status read shows overrun=1, next status read overrun=0; non-FIFO build: push 01,02 -> reads 01, overrun=1.
- Buffer full, rx_valid and read same cycle -> no overrun, new byte appears at tail.
- Assert rst while holding full and count nonzero -> next cycle rda=0, tbr=1, no tx_start, divisor reads 16'h028B.

Source files
------------

// File: rtl/spart_bus_if_if.sv
// Processor-side control signals of the SPART bus responder. databus is the
// shared tristate data line and is wired as a plain inout port on the top level.
interface spart_bus_if_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic       rda;
  logic       tbr;

  modport master (
    output iocs,
    output iorw,
    output ioaddr,
    input  rda,
    input  tbr
  );

  modport slave (
    input  iocs,
    input  iorw,
    input  ioaddr,
    output rda,
    output tbr
  );
endinterface

// File: rtl/spart_bus_if.sv
// SPART bus responder: I/O decode, baud divisor and 16x enable, tx holding register, rx buffer.
// Build option SPART_RX_FIFO_EN selects a 4-entry rx FIFO instead of a single rx register.
module spart_bus_if (
  input  logic             clk,
  input  logic             rst,
  spart_bus_if_if.slave    bus,
  inout  wire  [7:0]       databus,
  output logic             baud_en,
  output logic [7:0]       tx_data,
  output logic             tx_start,
  input  logic             tx_busy,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid
);

  localparam logic [7:0] DBL_RST = 8'h8B;
  localparam logic [7:0] DBH_RST = 8'h02;

  logic        w_rd;
  logic        w_wr;
  logic        w_wr_data;
  logic        w_wr_dbl;
  logic        w_wr_dbh;
  logic        w_rd_data;
  logic        w_rd_stat;
  logic [7:0]  w_wdata;
  logic [7:0]  w_rdata;
  logic [15:0] w_div_new;

  logic [7:0]  r_dbl;
  logic [7:0]  r_dbh;
  logic [15:0] r_baud_cnt;
  logic        r_baud_en;

  logic [7:0]  r_tx_hold;
  logic        r_tx_full;
  logic [7:0]  r_tx_data;
  logic        r_tx_start;

  logic        r_overrun;
  logic        w_rx_empty;
  logic        w_rx_full;
  logic [7:0]  w_rx_head;
  logic        w_rx_pop;
  logic        w_rx_push;
  logic        w_ovr_set;

  assign w_rd      = bus.iocs & bus.iorw;
  assign w_wr      = bus.iocs & ~bus.iorw;
  assign w_wr_data = w_wr & (bus.ioaddr == 2'b00);
  assign w_wr_dbl  = w_wr & (bus.ioaddr == 2'b10);
  assign w_wr_dbh  = w_wr & (bus.ioaddr == 2'b11);
  assign w_rd_data = w_rd & (bus.ioaddr == 2'b00);
  assign w_rd_stat = w_rd & (bus.ioaddr == 2'b01);
  assign w_wdata   = databus;

  // New divisor = written byte combined with the byte that is not being written
  assign w_div_new = w_wr_dbh ? {w_wdata, r_dbl} : {r_dbh, w_wdata};

  always_comb begin
    w_rdata = 8'h00;
    case (bus.ioaddr)
      2'b00:   w_rdata = w_rx_empty ? 8'h00 : w_rx_head;
      2'b01:   w_rdata = {5'b00000, r_overrun, ~r_tx_full, ~w_rx_empty};
      2'b10:   w_rdata = r_dbl;
      2'b11:   w_rdata = r_dbh;
      default: w_rdata = 8'h00;
    endcase
  end

  assign databus = w_rd ? w_rdata : 8'hzz;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dbl <= DBL_RST;
      r_dbh <= DBH_RST;
    end else if (w_wr_dbl) begin
      r_dbl <= w_wdata;
    end else if (w_wr_dbh) begin
      r_dbh <= w_wdata;
    end
  end

  // Divisor writes restart the period immediately; otherwise count down and reload at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      r_baud_cnt <= {DBH_RST, DBL_RST};
      r_baud_en  <= 1'b0;
    end else if (w_wr_dbl | w_wr_dbh) begin
      r_baud_cnt <= w_div_new;
      r_baud_en  <= 1'b0;
    end else if (r_baud_cnt == 16'h0000) begin
      r_baud_cnt <= {r_dbh, r_dbl};
      r_baud_en  <= 1'b1;
    end else begin
      r_baud_cnt <= r_baud_cnt - 16'h0001;
      r_baud_en  <= 1'b0;
    end
  end

  // Holding register hands off to the core whenever it is idle; writes while full are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_hold  <= 8'h00;
      r_tx_full  <= 1'b0;
      r_tx_data  <= 8'h00;
      r_tx_start <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      if (r_tx_full & ~tx_busy) begin
        r_tx_start <= 1'b1;
        r_tx_data  <= r_tx_hold;
        r_tx_full  <= 1'b0;
      end else if (w_wr_data & ~r_tx_full) begin
        r_tx_hold <= w_wdata;
        r_tx_full <= 1'b1;
      end
    end
  end

  assign w_rx_pop  = w_rd_data & ~w_rx_empty;
  assign w_rx_push = rx_valid & (~w_rx_full | w_rx_pop);
  assign w_ovr_set = rx_valid & w_rx_full & ~w_rx_pop;

`ifdef SPART_RX_FIFO_EN
  logic [7:0] r_rx_mem [0:3];
  logic [1:0] r_rx_wp;
  logic [1:0] r_rx_rp;
  logic [2:0] r_rx_cnt;

  assign w_rx_empty = (r_rx_cnt == 3'd0);
  assign w_rx_full  = (r_rx_cnt == 3'd4);
  assign w_rx_head  = r_rx_mem[r_rx_rp];

  always_ff @(posedge clk) begin
    if (w_rx_push) begin
      r_rx_mem[r_rx_wp] <= rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_wp  <= 2'd0;
      r_rx_rp  <= 2'd0;
      r_rx_cnt <= 3'd0;
    end else begin
      if (w_rx_push) begin
        r_rx_wp <= r_rx_wp + 2'd1;
      end
      if (w_rx_pop) begin
        r_rx_rp <= r_rx_rp + 2'd1;
      end
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_cnt <= r_rx_cnt + 3'd1;
        2'b01:   r_rx_cnt <= r_rx_cnt - 3'd1;
        default: r_rx_cnt <= r_rx_cnt;
      endcase
    end
  end
`else
  logic [7:0] r_rx_hold;
  logic       r_rx_full;

  assign w_rx_empty = ~r_rx_full;
  assign w_rx_full  = r_rx_full;
  assign w_rx_head  = r_rx_hold;

  // A push in the same cycle as a pop replaces the byte and keeps the register full
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_hold <= 8'h00;
      r_rx_full <= 1'b0;
    end else if (w_rx_push) begin
      r_rx_hold <= rx_data;
      r_rx_full <= 1'b1;
    end else if (w_rx_pop) begin
      r_rx_full <= 1'b0;
    end
  end
`endif

  // A new overrun takes priority over the clear from a simultaneous status read
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overrun <= 1'b0;
    end else if (w_ovr_set) begin
      r_overrun <= 1'b1;
    end else if (w_rd_stat) begin
      r_overrun <= 1'b0;
    end
  end

  assign bus.rda  = ~w_rx_empty;
  assign bus.tbr  = ~r_tx_full;
  assign baud_en  = r_baud_en;
  assign tx_data  = r_tx_data;
  assign tx_start = r_tx_start;

endmodule

// File: tb/tb_spart_bus_if.sv
// Randomized self-checking bench for spart_bus_if against a queue-based behavioural model.
module tb_spart_bus_if;

`ifdef SPART_RX_FIFO_EN
  localparam int RX_DEPTH = 4;
`else
  localparam int RX_DEPTH = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       tb_drv;
  logic [7:0] tb_wd;
  wire  [7:0] databus;
  logic       baud_en;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic [7:0] rx_data;
  logic       rx_valid;

  always #5 clk = ~clk;

  spart_bus_if_if bus ();

  assign databus = tb_drv ? tb_wd : 8'hzz;

  spart_bus_if dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .databus  (databus),
    .baud_en  (baud_en),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_busy  (tx_busy),
    .rx_data  (rx_data),
    .rx_valid (rx_valid)
  );

  // behavioural model state
  logic [7:0] m_rxq[$];
  bit         m_ovr;
  bit         m_full;
  logic [7:0] m_hold;
  logic [7:0] m_txd;
  bit         m_start;
  bit         m_baud;
  logic [7:0] m_dbl;
  logic [7:0] m_dbh;
  int         m_phase;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic model_reset();
    m_rxq.delete();
    m_ovr   = 1'b0;
    m_full  = 1'b0;
    m_hold  = 8'h00;
    m_txd   = 8'h00;
    m_start = 1'b0;
    m_baud  = 1'b0;
    m_dbl   = 8'h8B;
    m_dbh   = 8'h02;
    m_phase = 0;
  endtask

  function automatic logic [7:0] model_read(input logic [1:0] a);
    case (a)
      2'b00:   return (m_rxq.size() != 0) ? m_rxq[0] : 8'h00;
      2'b01:   return {5'b00000, m_ovr, ~m_full, (m_rxq.size() != 0)};
      2'b10:   return m_dbl;
      default: return m_dbh;
    endcase
  endfunction

  task automatic do_reset(input bit busy);
    rst         = 1'b1;
    bus.iocs    = 1'b0;
    bus.iorw    = 1'b0;
    bus.ioaddr  = 2'b00;
    tb_drv      = 1'b0;
    tb_wd       = 8'h00;
    rx_valid    = 1'b0;
    rx_data     = 8'h00;
    tx_busy     = busy;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // One bus cycle: drive, capture read data mid-cycle, clock, advance the model.
  task automatic cycle(input bit cs, input bit rw, input logic [1:0] a, input logic [7:0] wd,
                       input bit rxv, input logic [7:0] rxd, input bit busy,
                       output logic [7:0] rd_obs, output logic [7:0] rd_exp);
    bit rd;
    bit wr;
    bit pop;
    bit ovr_set;
    int d;
    bus.iocs   = cs;
    bus.iorw   = rw;
    bus.ioaddr = a;
    tb_drv     = cs & ~rw;
    tb_wd      = wd;
    rx_valid   = rxv;
    rx_data    = rxd;
    tx_busy    = busy;
    #4;
    rd_obs = databus;
    rd_exp = model_read(a);
    @(posedge clk);
    rd      = cs & rw;
    wr      = cs & ~rw;
    pop     = rd && (a == 2'b00) && (m_rxq.size() != 0);
    ovr_set = rxv && (m_rxq.size() == RX_DEPTH) && !pop;
    if (pop) void'(m_rxq.pop_front());
    if (rxv && !ovr_set) m_rxq.push_back(rxd);
    if (ovr_set) m_ovr = 1'b1;
    else if (rd && (a == 2'b01)) m_ovr = 1'b0;
    m_start = 1'b0;
    if (m_full && !busy) begin
      m_start = 1'b1;
      m_txd   = m_hold;
      m_full  = 1'b0;
    end else if (wr && (a == 2'b00) && !m_full) begin
      m_hold = wd;
      m_full = 1'b1;
    end
    if (wr && (a == 2'b10)) begin
      m_dbl = wd; m_phase = 0; m_baud = 1'b0;
    end else if (wr && (a == 2'b11)) begin
      m_dbh = wd; m_phase = 0; m_baud = 1'b0;
    end else begin
      d       = int'({m_dbh, m_dbl}) + 1;
      m_phase = m_phase + 1;
      m_baud  = ((m_phase % d) == 0);
    end
    #1;
    tb_drv   = 1'b0;
    bus.iocs = 1'b0;
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] ro, re;
    do_reset(1'b0);
    n_cmp++; if (bus.rda !== 1'b0) begin n_fail++; $display("FAIL reset_rda: got %b want 0", bus.rda); end
    n_cmp++; if (bus.tbr !== 1'b1) begin n_fail++; $display("FAIL reset_tbr: got %b want 1", bus.tbr); end
    n_cmp++; if (baud_en !== 1'b0) begin n_fail++; $display("FAIL reset_baud_en: got %b want 0", baud_en); end
    n_cmp++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
    n_cmp++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    cycle(1'b1, 1'b1, 2'b10, 8'h00, 1'b0, 8'h00, 1'b0, ro, re);
    n_cmp++; if (ro !== 8'h8B) begin n_fail++; $display("FAIL reset_dbl: got %h want 8b", ro); end
    cycle(1'b1, 1'b1, 2'b11, 8'h00, 1'b0, 8'h00, 1'b0, ro, re);
    n_cmp++; if (ro !== 8'h02) begin n_fail++; $display("FAIL reset_dbh: got %h want 02", ro); end
    cycle(1'b1, 1'b1, 2'b01, 8'h00, 1'b0, 8'h00, 1'b0, ro, re);
    n_cmp++; if (ro !== 8'h02) begin n_fail++; $display("FAIL reset_status: got %h want 02", ro); end
  endtask

  task automatic test_baud();
    logic [7:0] ro, re;
    int pulses;
    pulses = 0;
    cycle(1'b1, 1'b0, 2'b11, 8'h00, 1'b0, 8'h00, 1'b0, ro, re);
    cycle(1'b1, 1'b0, 2'b10, 8'h03, 1'b0, 8'h00, 1'b0, ro, re);
    for (int i = 1; i <= 12; i++) begin
      cycle(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 8'h00, 1'b0, ro, re);
      n_cmp++;
      if (baud_en !== ((i % 4) == 0)) begin
        n_fail++; $display("FAIL baud_div3 cyc%0d: got %b want %b", i, baud_en, ((i % 4) == 0));
      end
      if (baud_en === 1'b1) pulses++;
    end
    n_cmp++; if (pulses != 3) begin n_fail++; $display("FAIL baud_pulse_count: got %0d want 3", pulses); end
    cycle(1'b1, 1'b0, 2'b10, 8'h00, 1'b0, 8'h00, 1'b0, ro, re);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 8'h00, 1'b0, ro, re);
      n_cmp++; if (baud_en !== 1'b1) begin n_fail++; $display("FAIL baud_div0 cyc%0d: got %b want 1", i, baud_en); end
    end
    cycle(1'b1, 1'b0, 2'b10, 8'h03, 1'b0, 8'h00, 1'b0, ro, re);
  endtask

  task automatic test_tx();
    logic [7:0] ro, re;
    cycle(1'b1, 1'b0, 2'b00, 8'h41, 1'b0, 8'h00, 1'b0, ro, re);
    n_cmp++; if (bus.tbr !== 1'b0) begin n_fail++; $display("FAIL tx_tbr_fall: got %b want 0", bus.tbr); end
    n_cmp++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL tx_start_early: got %b want 0", tx_start); end
    cycle(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 8'h00, 1'b0, ro, re);
    n_cmp++; if (tx_start !== 1'b1) begin n_fail++; $display("FAIL tx_start_pulse: got %b want 1", tx_start); end
    n_cmp++; if (tx_data !== 8'h41) begin n_fail++; $display("FAIL tx_data_41: got %h want 41", tx_data); end
    n_cmp++; if (bus.tbr !== 1'b1) begin n_fail++; $display("FAIL tx_tbr_rise: got %b want 1", bus.tbr); end
    cycle(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 8'h00, 1'b0, ro, re);
    n_cmp++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL tx_start_one_cycle: got %b want 0", tx_start); end
    cycle(1'b1, 1'b0, 2'b00, 8'h42, 1'b0, 8'h00, 1'b1, ro, re);
    cycle(1'b1, 1'b0, 2'b00, 8'h43, 1'b0, 8'h00, 1'b1, ro, re);
    cycle(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 8'h00, 1'b1, ro, re);
    n_cmp++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL tx_busy_hold: got %b want 0", tx_start); end
    n_cmp++; if (tx_data !== 8'h41) begin n_fail++; $display("FAIL tx_data_kept: got %h want 41", tx_data); end
    cycle(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 8'h00, 1'b0, ro, re);
    n_cmp++; if (tx_start !== 1'b1) begin n_fail++; $display("FAIL tx_start_after_busy: got %b want 1", tx_start); end
    n_cmp++; if (tx_data !== 8'h42) begin n_fail++; $display("FAIL tx_drop_second: got %h want 42", tx_data); end
  endtask

  task automatic test_rx();
    logic [7:0] ro, re;
    cycle(1'b0, 1'b0, 2'b00, 8'h00, 1'b1, 8'h5A, 1'b0, ro, re);
    n_cmp++; if (bus.rda !== 1'b1) begin n_fail++; $display("FAIL rx_rda_set: got %b want 1", bus.rda); end
    cycle(1'b1, 1'b1, 2'b00, 8'h00, 1'b0, 8'h00, 1'b0, ro, re);
    n_cmp++; if (ro !== 8'h5A) begin n_fail++; $display("FAIL rx_read: got %h want 5a", ro); end
    n_cmp++; if (bus.rda !== 1'b0) begin n_fail++; $display("FAIL rx_rda_clear: got %b want 0", bus.rda); end
    cycle(1'b1, 1'b1, 2'b00, 8'h00, 1'b0, 8'h00, 1'b0, ro, re);
    n_cmp++; if (ro !== 8'h00) begin n_fail++; $display("FAIL rx_read_empty: got %h want 00", ro); end
  endtask

  task automatic test_overrun();
    logic [7:0] ro, re;
    for (int i = 1; i <= RX_DEPTH + 1; i++) begin
      cycle(1'b0, 1'b0, 2'b00, 8'h00, 1'b1, 8'(i), 1'b0, ro, re);
    end
    for (int i = 1; i <= RX_DEPTH; i++) begin
      cycle(1'b1, 1'b1, 2'b00, 8'h00, 1'b0, 8'h00, 1'b0, ro, re);
      n_cmp++; if (ro !== 8'(i)) begin n_fail++; $display("FAIL ovr_order%0d: got %h want %h", i, ro, 8'(i)); end
    end
    n_cmp++; if (bus.rda !== 1'b0) begin n_fail++; $display("FAIL ovr_drained: got %b want 0", bus.rda); end
    cycle(1'b1, 1'b1, 2'b01, 8'h00, 1'b0, 8'h00, 1'b0, ro, re);
    n_cmp++; if (ro[2] !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b want 1", ro[2]); end
    cycle(1'b1, 1'b1, 2'b01, 8'h00, 1'b0, 8'h00, 1'b0, ro, re);
    n_cmp++; if (ro[2] !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b want 0", ro[2]); end
  endtask

  task automatic test_full_pushpop();
    logic [7:0] ro, re;
    for (int i = 0; i < RX_DEPTH; i++) begin
      cycle(1'b0, 1'b0, 2'b00, 8'h00, 1'b1, 8'(8'hA0 + i), 1'b0, ro, re);
    end
    cycle(1'b1, 1'b1, 2'b00, 8'h00, 1'b1, 8'hC3, 1'b0, ro, re);
    n_cmp++; if (ro !== 8'hA0) begin n_fail++; $display("FAIL pp_head: got %h want a0", ro); end
    cycle(1'b1, 1'b1, 2'b01, 8'h00, 1'b0, 8'h00, 1'b0, ro, re);
    n_cmp++; if (ro[2] !== 1'b0) begin n_fail++; $display("FAIL pp_no_overrun: got %b want 0", ro[2]); end
    for (int i = 1; i <= RX_DEPTH; i++) begin
      cycle(1'b1, 1'b1, 2'b00, 8'h00, 1'b0, 8'h00, 1'b0, ro, re);
      n_cmp++;
      if (ro !== ((i == RX_DEPTH) ? 8'hC3 : 8'(8'hA0 + i))) begin
        n_fail++; $display("FAIL pp_drain%0d: got %h want %h", i, ro, ((i == RX_DEPTH) ? 8'hC3 : 8'(8'hA0 + i)));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] ro, re;
    cycle(1'b1, 1'b0, 2'b10, 8'h05, 1'b0, 8'h00, 1'b1, ro, re);
    cycle(1'b1, 1'b0, 2'b00, 8'h77, 1'b0, 8'h00, 1'b1, ro, re);
    cycle(1'b0, 1'b0, 2'b00, 8'h00, 1'b1, 8'h11, 1'b1, ro, re);
    n_cmp++; if ({bus.rda, bus.tbr} !== 2'b10) begin n_fail++; $display("FAIL mid_prestate: got %b want 10", {bus.rda, bus.tbr}); end
    do_reset(1'b0);
    n_cmp++; if (bus.rda !== 1'b0) begin n_fail++; $display("FAIL mid_rda: got %b want 0", bus.rda); end
    n_cmp++; if (bus.tbr !== 1'b1) begin n_fail++; $display("FAIL mid_tbr: got %b want 1", bus.tbr); end
    n_cmp++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL mid_tx_start: got %b want 0", tx_start); end
    cycle(1'b1, 1'b1, 2'b10, 8'h00, 1'b0, 8'h00, 1'b0, ro, re);
    n_cmp++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL mid_no_start: got %b want 0", tx_start); end
    n_cmp++; if (ro !== 8'h8B) begin n_fail++; $display("FAIL mid_dbl: got %h want 8b", ro); end
    cycle(1'b1, 1'b1, 2'b11, 8'h00, 1'b0, 8'h00, 1'b0, ro, re);
    n_cmp++; if (ro !== 8'h02) begin n_fail++; $display("FAIL mid_dbh: got %h want 02", ro); end
  endtask

  task automatic test_random();
    logic [7:0] ro, re;
    bit cs, rw, rxv, busy;
    logic [1:0] a;
    for (int i = 0; i < 600; i++) begin
      cs   = ($urandom_range(0, 2) != 0);
      rw   = $urandom_range(0, 1);
      a    = 2'($urandom_range(0, 3));
      if (!rw && a[1] && ($urandom_range(0, 3) != 0)) a = 2'b00;
      rxv  = ($urandom_range(0, 2) == 0);
      busy = ($urandom_range(0, 2) == 0);
      cycle(cs, rw, a, 8'($urandom_range(0, 255)), rxv, 8'($urandom_range(0, 255)), busy, ro, re);
      if (cs && rw) begin
        n_cmp++; if (ro !== re) begin n_fail++; $display("FAIL rnd_read%0d a=%0d: got %h want %h", i, a, ro, re); end
      end
      n_cmp++; if (bus.rda !== (m_rxq.size() != 0)) begin n_fail++; $display("FAIL rnd_rda%0d: got %b want %b", i, bus.rda, (m_rxq.size() != 0)); end
      n_cmp++; if (bus.tbr !== !m_full) begin n_fail++; $display("FAIL rnd_tbr%0d: got %b want %b", i, bus.tbr, !m_full); end
      n_cmp++; if (tx_start !== m_start) begin n_fail++; $display("FAIL rnd_tx_start%0d: got %b want %b", i, tx_start, m_start); end
      n_cmp++; if (tx_data !== m_txd) begin n_fail++; $display("FAIL rnd_tx_data%0d: got %h want %h", i, tx_data, m_txd); end
      n_cmp++; if (baud_en !== m_baud) begin n_fail++; $display("FAIL rnd_baud%0d: got %b want %b", i, baud_en, m_baud); end
    end
  endtask

  initial begin
    test_reset();
    test_baud();
    test_tx();
    test_rx();
    test_overrun();
    test_full_pushpop();
    test_reset_mid();
    do_reset(1'b0);
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
